// File: rtl/mem_arbiter.sv
// mem_arbiter: single-owner IF/PF/LSB scheduler for the byte-serial memory controller.
// Define MEM_ARB_PERF_EN to add the 32-bit grant/starvation performance counters.
module mem_arbiter #(
    parameter int IF_LEN       = 4,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback,
    input  logic                if_req,
    input  logic [31:0]         if_addr,
    output logic                if_done,
    output logic [8*IF_LEN-1:0] if_data,
    input  logic                pf_req,
    input  logic [31:0]         pf_addr,
    output logic                pf_done,
    input  logic                lsb_req,
    input  logic                lsb_wr,
    input  logic [31:0]         lsb_addr,
    input  logic [2:0]          lsb_len,
    input  logic [31:0]         lsb_wdata,
    output logic                lsb_done,
    output logic [31:0]         lsb_rdata,
    output logic                mc_en,
    output logic                mc_wr,
    output logic [31:0]         mc_addr,
    output logic [2:0]          mc_len,
    output logic [31:0]         mc_wdata,
    output logic                mc_is_if,
    input  logic                mc_done,
    input  logic [31:0]         mc_rdata,
`ifdef MEM_ARB_PERF_EN
    input  logic [8*IF_LEN-1:0] mc_if_data,
    output logic [31:0]         perf_if_grants,
    output logic [31:0]         perf_pf_grants,
    output logic [31:0]         perf_lsb_grants,
    output logic [31:0]         perf_starve_forces
`else
    input  logic [8*IF_LEN-1:0] mc_if_data
`endif
);
    typedef enum logic [1:0] {IDLE, BUSY, COOL} state_t;
    typedef enum logic [1:0] {O_NONE, O_IF, O_PF, O_LSB} owner_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic [CNT_W-1:0]    starve_q, starve_d;
    logic                discard_q, discard_d;
    logic                mc_wr_q, mc_wr_d;
    logic [31:0]         mc_addr_q, mc_addr_d;
    logic [2:0]          mc_len_q, mc_len_d;
    logic [31:0]         mc_wdata_q, mc_wdata_d;
    logic                mc_is_if_q, mc_is_if_d;
    logic                if_done_q, if_done_d;
    logic                pf_done_q, pf_done_d;
    logic                lsb_done_q, lsb_done_d;
    logic [8*IF_LEN-1:0] if_data_q, if_data_d;
    logic [31:0]         lsb_rdata_q, lsb_rdata_d;

    logic force_if, g_if, g_lsb, g_pf, grant, abort, fetch_rb;

    assign force_if = if_req && starve_q == LIMIT;
    assign g_if     = if_req && (force_if || !lsb_req);
    assign g_lsb    = lsb_req && !g_if;
    assign g_pf     = pf_req && !lsb_req && !if_req;
    assign grant    = rdy && state_q == IDLE && !rollback && (g_if || g_lsb || g_pf);
    // A load cannot be resumed once flushed, so it is abandoned; fetches must still drain.
    assign abort    = rollback && owner_q == O_LSB && !mc_wr_q;
    assign fetch_rb = rollback && mc_is_if_q;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        discard_d   = discard_q;
        mc_wr_d     = mc_wr_q;
        mc_addr_d   = mc_addr_q;
        mc_len_d    = mc_len_q;
        mc_wdata_d  = mc_wdata_q;
        mc_is_if_d  = mc_is_if_q;
        if_done_d   = 1'b0;
        pf_done_d   = 1'b0;
        lsb_done_d  = 1'b0;
        if_data_d   = if_data_q;
        lsb_rdata_d = lsb_rdata_q;
        if (rdy && state_q == IDLE) begin
            if (!if_req) starve_d = '0;
            if (grant) begin
                state_d    = BUSY;
                owner_d    = g_lsb ? O_LSB : (g_if ? O_IF : O_PF);
                discard_d  = 1'b0;
                mc_wr_d    = g_lsb && lsb_wr;
                mc_addr_d  = g_lsb ? lsb_addr : (g_if ? if_addr : pf_addr);
                mc_len_d   = g_lsb ? lsb_len : 3'(IF_LEN);
                mc_wdata_d = g_lsb ? lsb_wdata : '0;
                mc_is_if_d = !g_lsb;
                if (g_if) starve_d = '0;
                else if (g_lsb && if_req && starve_q != '1) starve_d = starve_q + CNT_W'(1);
            end
        end else if (rdy && state_q == BUSY) begin
            if (abort) begin
                state_d = IDLE;
                owner_d = O_NONE;
            end else if (mc_done) begin
                state_d   = COOL;
                owner_d   = O_NONE;
                discard_d = 1'b0;
                if (!discard_q && !fetch_rb) begin
                    if_done_d   = owner_q == O_IF;
                    pf_done_d   = owner_q == O_PF;
                    lsb_done_d  = owner_q == O_LSB;
                    if_data_d   = mc_is_if_q ? mc_if_data : if_data_q;
                    lsb_rdata_d = mc_is_if_q ? lsb_rdata_q : mc_rdata;
                end
            end else if (fetch_rb) begin
                discard_d = 1'b1;
            end
        end else if (rdy && state_q == COOL) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= O_NONE;
            starve_q    <= '0;
            discard_q   <= 1'b0;
            mc_wr_q     <= 1'b0;
            mc_addr_q   <= '0;
            mc_len_q    <= '0;
            mc_wdata_q  <= '0;
            mc_is_if_q  <= 1'b0;
            if_done_q   <= 1'b0;
            pf_done_q   <= 1'b0;
            lsb_done_q  <= 1'b0;
            if_data_q   <= '0;
            lsb_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            discard_q   <= discard_d;
            mc_wr_q     <= mc_wr_d;
            mc_addr_q   <= mc_addr_d;
            mc_len_q    <= mc_len_d;
            mc_wdata_q  <= mc_wdata_d;
            mc_is_if_q  <= mc_is_if_d;
            if_done_q   <= if_done_d;
            pf_done_q   <= pf_done_d;
            lsb_done_q  <= lsb_done_d;
            if_data_q   <= if_data_d;
            lsb_rdata_q <= lsb_rdata_d;
        end
    end

    // The controller must never see a request while the pipeline is stalled.
    assign mc_en     = state_q == BUSY && rdy;
    assign mc_wr     = mc_wr_q;
    assign mc_addr   = mc_addr_q;
    assign mc_len    = mc_len_q;
    assign mc_wdata  = mc_wdata_q;
    assign mc_is_if  = mc_is_if_q;
    assign if_done   = if_done_q;
    assign pf_done   = pf_done_q;
    assign lsb_done  = lsb_done_q;
    assign if_data   = if_data_q;
    assign lsb_rdata = lsb_rdata_q;

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_if_grants     <= '0;
            perf_pf_grants     <= '0;
            perf_lsb_grants    <= '0;
            perf_starve_forces <= '0;
        end else if (grant) begin
            perf_if_grants     <= perf_if_grants + {31'b0, g_if};
            perf_pf_grants     <= perf_pf_grants + {31'b0, g_pf};
            perf_lsb_grants    <= perf_lsb_grants + {31'b0, g_lsb};
            perf_starve_forces <= perf_starve_forces + {31'b0, force_if};
        end
    end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
    localparam int LIMIT = 4;

    logic clk = 0, rst = 0, rdy = 1, rollback = 0;
    logic if_req = 0, pf_req = 0, lsb_req = 0, lsb_wr = 0, mc_done = 0;
    logic [31:0] if_addr = 0, pf_addr = 0, lsb_addr = 0, lsb_wdata = 0, mc_rdata = 0, mc_if_data = 0;
    logic [2:0] lsb_len = 0;
    logic if_done, pf_done, lsb_done, mc_en, mc_wr, mc_is_if;
    logic [31:0] if_data, lsb_rdata, mc_addr, mc_wdata;
    logic [2:0] mc_len;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .pf_req(pf_req), .pf_addr(pf_addr), .pf_done(pf_done),
        .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mc_en(mc_en), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_len(mc_len),
        .mc_wdata(mc_wdata), .mc_is_if(mc_is_if), .mc_done(mc_done),
        .mc_rdata(mc_rdata), .mc_if_data(mc_if_data)
    );

    always #5 clk = ~clk;

    // Reference model: who (0=IF, 1=PF, 2=LSB) owns the controller and the expected outputs.
    bit m_busy, m_cool, m_disc, rnd_data = 1, hold_lsb = 0;
    int m_who, m_starve, bc, lat;
    logic e_wr, e_is_if, e_ifd, e_pfd, e_lsbd;
    logic [31:0] e_addr, e_wdata, e_if_data, e_rdata;
    logic [2:0] e_len;
    int checks, errors, n_ifd, n_lsbd;
    logic prev_en = 0;
    logic [31:0] grants[$];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int winner();
        if (if_req && m_starve == LIMIT) return 0;
        if (lsb_req) return 2;
        if (if_req) return 0;
        if (pf_req) return 1;
        return -1;
    endfunction

    task automatic tick();
        int w;
        mc_done = rst && rdy && m_busy && bc == lat;
        if (rst && rdy && m_busy) bc++;
        if (rnd_data) begin
            mc_rdata = $urandom;
            mc_if_data = $urandom;
        end
        e_ifd = 0; e_pfd = 0; e_lsbd = 0;
        if (!rst) begin
            m_busy = 0; m_cool = 0; m_disc = 0; m_starve = 0;
            e_wr = 0; e_addr = 0; e_len = 0; e_wdata = 0; e_is_if = 0; e_if_data = 0; e_rdata = 0;
        end else if (rdy && m_cool) begin
            m_cool = 0;
        end else if (rdy && !m_busy) begin
            if (!if_req) m_starve = 0;
            w = winner();
            if (!rollback && w >= 0) begin
                m_busy = 1; m_who = w; m_disc = 0; bc = 0;
                e_addr = w == 2 ? lsb_addr : (w == 0 ? if_addr : pf_addr);
                e_len = w == 2 ? lsb_len : 3'd4;
                e_wr = w == 2 && lsb_wr;
                e_wdata = w == 2 ? lsb_wdata : 32'd0;
                e_is_if = w != 2;
                if (w == 0) m_starve = 0;
                else if (w == 2 && if_req && m_starve < 7) m_starve++;
            end
        end else if (rdy) begin
            if (rollback && m_who == 2 && !e_wr) m_busy = 0;
            else if (mc_done) begin
                m_busy = 0; m_cool = 1;
                if (!m_disc && !(rollback && m_who != 2)) begin
                    e_ifd = m_who == 0; e_pfd = m_who == 1; e_lsbd = m_who == 2;
                    if (m_who == 2) e_rdata = mc_rdata;
                    else e_if_data = mc_if_data;
                end
                m_disc = 0;
            end else if (rollback && m_who != 2) m_disc = 1;
        end
        @(posedge clk);
        #1;
        check("mc_en", mc_en, m_busy && rdy);
        check("mc_wr", mc_wr, e_wr);
        check("mc_addr", mc_addr, e_addr);
        check("mc_len", mc_len, e_len);
        check("mc_wdata", mc_wdata, e_wdata);
        check("mc_is_if", mc_is_if, e_is_if);
        check("if_done", if_done, e_ifd);
        check("pf_done", pf_done, e_pfd);
        check("lsb_done", lsb_done, e_lsbd);
        check("if_data", if_data, e_if_data);
        check("lsb_rdata", lsb_rdata, e_rdata);
        if (mc_en && !prev_en) grants.push_back(mc_addr);
        prev_en = mc_en;
        n_ifd += int'(if_done);
        n_lsbd += int'(lsb_done);
        if (e_ifd) if_req = 0;
        if (e_pfd) pf_req = 0;
        if (e_lsbd && !hold_lsb) lsb_req = 0;
    endtask

    initial begin
        int k;
        tick(); tick();
        check("rst_mc_en", mc_en, 0);
        rst = 1;
        tick();
        // IF only with fixed fetch data
        rnd_data = 0; mc_if_data = 32'h00130293; if_addr = 32'h100; lat = 4; if_req = 1;
        tick();
        check("t1_en", mc_en, 1);
        check("t1_len", mc_len, 4);
        check("t1_is_if", mc_is_if, 1);
        for (int i = 0; i < 20 && !e_ifd; i++) tick();
        check("t1_done", if_done, 1);
        check("t1_data", if_data, 32'h00130293);
        tick();
        check("t1_cool", mc_en, 0);
        rnd_data = 1;
        repeat (3) tick();
        // contention: LSB, then IF, then PF
        grants.delete();
        lsb_wr = 0; lsb_addr = 32'h2000; lsb_len = 4; if_addr = 32'h500; pf_addr = 32'h600;
        lat = $urandom_range(0, 3); lsb_req = 1; if_req = 1; pf_req = 1;
        repeat (30) tick();
        check("t2_n", grants.size(), 3);
        if (grants.size() == 3) begin
            check("t2_g0", grants[0], 32'h2000);
            check("t2_g1", grants[1], 32'h500);
            check("t2_g2", grants[2], 32'h600);
        end
        // starvation
        grants.delete();
        hold_lsb = 1; lsb_addr = 32'h3000; if_addr = 32'h400; lat = 0; lsb_req = 1; if_req = 1;
        for (int i = 0; i < 80 && grants.size() < 5; i++) tick();
        check("t3_n", grants.size(), 5);
        for (k = 0; k < grants.size() && k < 5; k++) check("t3_g", grants[k], k == 4 ? 32'h400 : 32'h3000);
        for (int i = 0; i < 20 && !e_ifd; i++) tick();
        if_req = 1;
        for (int i = 0; i < 40 && grants.size() < 6; i++) tick();
        check("t3_after", grants.size() == 6 ? grants[5] : 32'hdead, 32'h3000);
        hold_lsb = 0; lsb_req = 0;
        repeat (20) tick();
        // rollback two cycles into a load
        lsb_wr = 0; lsb_addr = $urandom; lsb_len = 2; lat = 10; lsb_req = 1;
        tick(); tick(); tick();
        rollback = 1;
        tick();
        rollback = 0;
        check("t4_drop", mc_en, 0);
        check("t4_nodone", lsb_done, 0);
        lat = 1;
        tick();
        check("t4_regrant", mc_en, 1);
        repeat (10) tick();
        // rollback during a fetch
        k = n_ifd;
        if_addr = $urandom; lat = 5; if_req = 1;
        tick(); tick();
        rollback = 1; if_req = 0;
        tick();
        rollback = 0;
        repeat (12) tick();
        check("t5_fetch_swallowed", n_ifd, k);
        // rollback during a store
        k = n_lsbd;
        lsb_wr = 1; lsb_addr = 32'h30000; lsb_wdata = 32'h41; lsb_len = 1; lat = 3; lsb_req = 1;
        tick();
        check("t5_st_wdata", mc_wdata, 32'h41);
        tick();
        rollback = 1;
        tick();
        rollback = 0;
        repeat (8) tick();
        check("t5_store_done", n_lsbd, k + 1);
        // rollback coinciding with mc_done
        lat = 2; if_req = 1;
        tick(); tick(); tick();
        rollback = 1; if_req = 0;
        tick();
        rollback = 0;
        check("t5_sim_fetch", if_done, 0);
        repeat (4) tick();
        lat = 0; lsb_wr = 1; lsb_req = 1;
        tick();
        rollback = 1;
        tick();
        rollback = 0;
        check("t5_sim_store", lsb_done, 1);
        repeat (4) tick();
        lsb_wr = 0; lsb_req = 1;
        tick();
        rollback = 1; lsb_req = 0;
        tick();
        rollback = 0;
        check("t5_sim_load", lsb_done, 0);
        repeat (4) tick();
        // reset mid-BUSY, then rdy stall
        lat = 10; if_req = 1;
        tick(); tick();
        rst = 0;
        tick();
        check("t6_rst_en", mc_en, 0);
        check("t6_rst_addr", mc_addr, 0);
        rst = 1;
        k = n_ifd;
        tick(); tick();
        rdy = 0;
        repeat (3) begin
            tick();
            check("t6_frozen_en", mc_en, 0);
        end
        lat = bc + 2; rdy = 1;
        for (int i = 0; i < 20 && n_ifd == k; i++) tick();
        check("t6_resume_done", n_ifd, k + 1);
        repeat (4) tick();
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rdy = $urandom_range(0, 7) != 0;
            rollback = $urandom_range(0, 15) == 0;
            if (!m_busy) lat = $urandom_range(0, 4);
            if (!if_req && $urandom_range(0, 2) == 0) begin if_req = 1; if_addr = $urandom; end
            if (!pf_req && $urandom_range(0, 3) == 0) begin pf_req = 1; pf_addr = $urandom; end
            if (!lsb_req && $urandom_range(0, 2) == 0) begin
                lsb_req = 1; lsb_wr = $urandom_range(0, 1) == 1; lsb_addr = $urandom;
                lsb_wdata = $urandom; k = $urandom_range(0, 2); lsb_len = 3'(1 << k);
            end
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-owner scheduler in front of the byte-serial memory controller.
- Accepts level-held requests from three requesters and issues one transaction at a time on the controller's enable/done port: instruction fetch (IF), load/store buffer (LSB) and instruction prefetcher (PF).
- Enforces priority with IF starvation protection, handles rollback, and guarantees the controller's one-cycle post-done turnaround.

Parameters:
- IF_LEN, 4, bytes per IF/PF fetch; driven on mc_len for IF/PF grants.
- STARVE_LIMIT, 4, consecutive LSB grants while IF is waiting before IF is forced.
- CNT_W, 3, width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock, posedge.
- rst  in  1  synchronous reset, active-low (rst=0 resets on posedge clk).
- rdy  in  1  global ready; when 0 the block holds all state and drives mc_en=0.
- rollback  in  1  pipeline flush pulse.
- if_req  in  1  IF request, level held until if_done.
- if_addr  in  32  IF byte address.
- if_done  out  1  one-cycle IF completion pulse.
- if_data  out  8*IF_LEN  fetched bytes, valid with if_done.
- pf_req  in  1  PF request, level held until pf_done.
- pf_addr  in  32  PF byte address.
- pf_done  out  1  one-cycle PF completion pulse; data on if_data.
- lsb_req  in  1  LSB request, level held until lsb_done.
- lsb_wr  in  1  1 = store.
- lsb_addr  in  32  LSB byte address.
- lsb_len  in  3  LSB access length in bytes (1, 2 or 4).
- lsb_wdata  in  32  store data.
- lsb_done  out  1  one-cycle LSB completion pulse.
- lsb_rdata  out  32  load data, valid with lsb_done.
- mc_en  out  1  controller request, held until mc_done.
- mc_wr  out  1  controller write select.
- mc_addr  out  32  controller address.
- mc_len  out  3  controller length.
- mc_wdata  out  32  controller store data.
- mc_is_if  out  1  1 = IF/PF transaction (controller's fetch path).
- mc_done  in  1  controller completion pulse.
- mc_rdata  in  32  controller load data.
- mc_if_data  in  8*IF_LEN  controller fetch data.

Behaviour:
- Reset (rst=0): state=IDLE, owner=NONE, starve_cnt=0, discard=0. All outputs 0: mc_en, mc_wr, mc_addr, mc_len, mc_wdata, mc_is_if, if_done, pf_done, lsb_done, if_data, lsb_rdata. Reset mid-transaction abandons it with no done pulse.
- All outputs are registered. Done pulses last exactly one cycle.
- States:
  - IDLE: arbitrate among requests sampled this cycle. The winner's fields are latched into the mc_* registers with mc_en=1 on the next edge; go to BUSY.
  - BUSY: hold mc_* stable until mc_done=1. Then forward data and pulse the owner's done (unless discard=1), drop mc_en, and go to COOL.
  - COOL: exactly one cycle with mc_en=0, owner's done low and no grant; go to IDLE.
- Grant-to-mc_en latency: 1 cycle. Minimum back-to-back spacing: mc_done, then COOL, then a new grant in IDLE, with mc_en rising on the following cycle.
- Priority: LSB > IF > PF, except when starve_cnt==STARVE_LIMIT and if_req=1, IF wins.
- starve_cnt:
  - increments (saturating) on each LSB grant while if_req=1;
  - clears on IF grant or when if_req=0 in IDLE.
- Rollback:
  - Rollback in IDLE or COOL suppresses that cycle's grant.
  - BUSY on an LSB load: the controller aborts, so return to IDLE immediately, drop mc_en, no lsb_done.
  - BUSY on an IF or PF fetch: set discard=1 and keep waiting for mc_done; that mc_done is swallowed with no if_done/pf_done, then COOL.
  - BUSY on a store: ignored; the store completes and lsb_done pulses.
- Simultaneous mc_done and rollback:
  - store: lsb_done still fires;
  - load: aborted, no lsb_done;
  - fetch: done suppressed.
- Requester deasserting req while granted: transaction completes, done still pulses.
- rdy=0: freeze state, counters and mc_* registers, force mc_en=0. mc_done cannot arrive while rdy=0.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- When defined: adds outputs perf_if_grants, perf_pf_grants, perf_lsb_grants and perf_starve_forces, each 32 bits. Each increments (wrapping) on the corresponding grant or forced IF grant; cleared by reset; frozen when rdy=0.
- When undefined: ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- IF only: if_req=1, if_addr=0x100, mc_done after 5 cycles with mc_if_data=0x00130293 -> mc_en=1 one cycle after request, mc_len=4, mc_is_if=1; if_done pulses once with if_data=0x00130293; COOL cycle with mc_en=0.
- Contention: lsb_req (load, addr 0x2000, len 4) and if_req asserted together -> LSB granted first; IF granted after the COOL cycle; pf_req also held -> PF granted third.
- Starvation: lsb_req held continuously, if_req=1, STARVE_LIMIT=4 -> four LSB grants, then IF granted fifth; starve_cnt returns to 0.
- Rollback on load: rollback pulse 2 cycles into an LSB load -> mc_en drops next cycle, no lsb_done, next grant on the following IDLE cycle.
- Rollback on fetch and store: rollback during IF -> mc_done swallowed, no if_done. Rollback during store (addr 0x30000, data 0x41, len 1) -> lsb_done still pulses.
- Reset and rdy: rst=0 mid-BUSY -> all outputs 0 next cycle. rdy=0 for 3 cycles in BUSY -> mc_en=0 while frozen, then transaction resumes and completes.
